// File: rtl/display_arbiter.sv
// Two-requester arbiter for the 4-digit seven-segment display: latches the
// granted value into d1..d4 and holds ownership for DWELL cycles.
module display_arbiter #(
  parameter int              CNT_W = 24,
  parameter logic [CNT_W-1:0] DWELL = 24'd5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] val0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] val1,
  output logic        ack1,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [3:0]  d4,
  output logic        owner,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_r;

  logic        want0_s;
  logic        want1_s;
  logic        take_s;
  logic        idx_s;
  logic [15:0] sel_val_s;

  // Request qualification and arbitration; a req seen while its ack is high is the old request.
  always_comb begin
    want0_s   = req0 & ~ack0;
    want1_s   = req1 & ~ack1;
    take_s    = 1'b0;
    idx_s     = 1'b0;
    sel_val_s = val0;
    case (state_r)
      IDLE: begin
        if (want0_s && want1_s) begin
          take_s = 1'b1;
          idx_s  = ~last_r;
        end else if (want0_s) begin
          take_s = 1'b1;
          idx_s  = 1'b0;
        end else if (want1_s) begin
          take_s = 1'b1;
          idx_s  = 1'b1;
        end else begin
          take_s = 1'b0;
          idx_s  = 1'b0;
        end
      end
      HOLD: begin
        idx_s  = owner;
        take_s = owner ? want1_s : want0_s;
      end
      default: begin
        take_s = 1'b0;
        idx_s  = 1'b0;
      end
    endcase
    if (idx_s) begin
      sel_val_s = val1;
    end else begin
      sel_val_s = val0;
    end
  end

  // State, dwell counter, display registers and ack pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      last_r  <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      d3      <= 4'd0;
      d4      <= 4'd0;
      owner   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack0 <= take_s & ~idx_s;
      ack1 <= take_s & idx_s;
      if (take_s) begin
        d1 <= sel_val_s[3:0];
        d2 <= sel_val_s[7:4];
        d3 <= sel_val_s[11:8];
        d4 <= sel_val_s[15:12];
      end
      case (state_r)
        IDLE: begin
          if (take_s) begin
            owner   <= idx_s;
            last_r  <= idx_s;
            cnt_r   <= DWELL - CNT_ONE;
            state_r <= HOLD;
            busy    <= 1'b1;
          end
        end
        HOLD: begin
          // Refreshes do not reload the counter, so dwell is never extended.
          if (cnt_r == '0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: vector table on a DWELL=4 instance and a
// back-to-back grant sequence on a DWELL=1 instance, via an expectation queue.
module tb_display_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req0, req1, ack0, ack1, owner, busy;
  logic [15:0] val0, val1;
  logic [3:0]  d1, d2, d3, d4;

  logic        reset_b, req0_b, req1_b, ack0_b, ack1_b, owner_b, busy_b;
  logic [15:0] val0_b, val1_b;
  logic [3:0]  d1_b, d2_b, d3_b, d4_b;

  display_arbiter #(.CNT_W(24), .DWELL(24'd4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .val0(val0), .ack0(ack0),
    .req1(req1), .val1(val1), .ack1(ack1), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .owner(owner), .busy(busy));

  display_arbiter #(.CNT_W(24), .DWELL(24'd1)) dut_d1 (
    .clk(clk), .reset(reset_b), .req0(req0_b), .val0(val0_b), .ack0(ack0_b),
    .req1(req1_b), .val1(val1_b), .ack1(ack1_b), .d1(d1_b), .d2(d2_b), .d3(d3_b), .d4(d4_b),
    .owner(owner_b), .busy(busy_b));

  typedef struct {
    logic        rst, r0, r1;
    logic [15:0] v0, v1;
    logic [19:0] exp;   // {ack0, ack1, owner, busy, d4..d1}
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] sb[$];
  int          total = 0;
  int          bad = 0;

  task automatic add(input logic rst, input logic r0, input logic [15:0] v0,
                     input logic r1, input logic [15:0] v1,
                     input logic a0, input logic a1, input logic own,
                     input logic bsy, input logic [15:0] disp);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.v0 = v0; v.r1 = r1; v.v1 = v1;
    v.exp = {a0, a1, own, bsy, disp};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [19:0] got);
    logic [19:0] want;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got {a0,a1,own,busy,disp}=%b_%b_%b_%b_%h required %b_%b_%b_%b_%h",
                 name, got[19], got[18], got[17], got[16], got[15:0],
                 want[19], want[18], want[17], want[16], want[15:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; val0 = 16'h0; val1 = 16'h0;
    reset_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; val0_b = 16'h0; val1_b = 16'h0;

    //   rst  r0    v0        r1    v1        a0    a1    own   busy  disp
    // single request, full dwell, then idle hold
    add(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b1, 16'h3A7F, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3A7F);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3A7F);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3A7F);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3A7F);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3A7F);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3A7F);
    // tie from reset: requester 0 first, requester 1 one cycle after busy falls
    add(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1111);
    add(1'b0, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2222);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2222);
    // non-owner request stays pending through requester 0's dwell
    add(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
    // owner refresh at dwell cycle 2 does not extend busy
    add(1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
    add(1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    // reset mid-dwell clears everything, then the tie pointer favours requester 0 again
    add(1'b0, 1'b1, 16'h00AA, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00AA);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA);
    add(1'b1, 1'b1, 16'h7777, 1'b1, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b1, 16'h7777, 1'b1, 16'h8888, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7777);
    add(1'b0, 1'b1, 16'h7777, 1'b1, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; req0 = tbl[i].r0; val0 = tbl[i].v0;
      req1 = tbl[i].r1; val1 = tbl[i].v1;
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {ack0, ack1, owner, busy, d4, d3, d2, d1});
    end

    // DWELL=1 with req1 held: ack1 and busy alternate every cycle
    @(negedge clk);
    reset_b = 1'b0; req1_b = 1'b1; val1_b = 16'hC0DE;
    for (int k = 1; k <= 8; k++) begin
      sb.push_back({1'b0, k[0], 1'b1, k[0], 16'hC0DE});
      @(posedge clk);
      #1;
      check($sformatf("dwell1_cyc%0d", k), {ack0_b, ack1_b, owner_b, busy_b, d4_b, d3_b, d2_b, d1_b});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
